// File: rtl/fm_pkg.sv
// Shared types and constants for the feature-map DDR readback controller.
package fm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } fm_state_t;

    localparam int unsigned FM_MW          = 144;
    localparam int unsigned FM_DDR_WIDTH   = 256;
    localparam int unsigned FM_RATIO_WORDS = 16;
    localparam int unsigned FM_RATIO_BEATS = 9;

endpackage

// File: rtl/fm_bit_packer.sv
// LSB-first bit accumulator: appends MW-bit words and emits DDR_WIDTH-bit beats
// over a valid/ready handshake, zero-padding the final partial beat on flush.
module fm_bit_packer #(
    parameter int unsigned MW        = 144,
    parameter int unsigned DDR_WIDTH = 256,
    parameter int unsigned FILL_W    = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [MW-1:0]        in_data,
    input  logic                 flush_next,
    input  logic                 out_ready,
    output logic [DDR_WIDTH-1:0] out_data,
    output logic                 out_valid,
    output logic [FILL_W-1:0]    fill_bits,
    output logic [FILL_W-1:0]    fill_next
);

    localparam int unsigned ACC_W = DDR_WIDTH + MW;

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_shift;
    logic [ACC_W-1:0]  acc_next;
    logic [FILL_W-1:0] fill_shift;
    logic              fire;

    // Shift out the departing beat first, then append above the remaining fill;
    // bits above fill_bits are always zero, so OR-ing in the new word is safe.
    always_comb begin
        fire       = out_valid && out_ready;
        acc_shift  = acc;
        fill_shift = fill_bits;
        if (fire) begin
            acc_shift  = acc >> DDR_WIDTH;
            fill_shift = (fill_bits > FILL_W'(DDR_WIDTH)) ? fill_bits - FILL_W'(DDR_WIDTH) : '0;
        end
        acc_next  = acc_shift;
        fill_next = fill_shift;
        if (in_valid) begin
            acc_next  = acc_shift | (ACC_W'(in_data) << fill_shift);
            fill_next = fill_shift + FILL_W'(MW);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            fill_bits <= '0;
            out_valid <= 1'b0;
        end else begin
            acc       <= acc_next;
            fill_bits <= fill_next;
            out_valid <= (fill_next >= FILL_W'(DDR_WIDTH)) || (flush_next && (fill_next != '0));
        end
    end

    assign out_data = acc[DDR_WIDTH-1:0];

endmodule

// File: rtl/fm_ddr_readback_ctrl.sv
// Reads a run of feature-map words and packs them into DDR beats.
// Optional macro FM_RD_STALL_CNT_EN enables the backpressure stall counter.
module fm_ddr_readback_ctrl #(
    parameter int unsigned CONV_OUT_NUM = 18,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned FM_MEM_DEPTH = 13,
    parameter int unsigned DDR_WIDTH    = 256
) (
    input  logic                                 calc_clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [FM_MEM_DEPTH-1:0]              base_addr,
    input  logic [FM_MEM_DEPTH:0]                word_count,
    output logic [FM_MEM_DEPTH-1:0]              fm_rd_addr,
    output logic                                 fm_rd_en,
    input  logic [CONV_OUT_NUM*DATA_WIDTH-1:0]   fm_rd_data,
    output logic [DDR_WIDTH-1:0]                 ddr_rd_data,
    output logic                                 ddr_rd_valid,
    input  logic                                 ddr_rd_ready,
    output logic                                 busy,
    output logic                                 done,
    output logic [15:0]                          stall_cnt
);

    import fm_pkg::*;

    localparam int unsigned MW     = CONV_OUT_NUM * DATA_WIDTH;
    localparam int unsigned FILL_W = $clog2(DDR_WIDTH + MW + 1);
    localparam int unsigned CREDIT = DDR_WIDTH + MW;
    localparam logic [FM_MEM_DEPTH:0]   ONE_CNT  = 1;
    localparam logic [FM_MEM_DEPTH-1:0] ONE_ADDR = 1;

    fm_state_t             state;
    fm_state_t             state_next;
    logic [FM_MEM_DEPTH:0] count_q;
    logic [FM_MEM_DEPTH:0] issued;
    logic                  inflight;
    logic                  accept;
    logic [FILL_W-1:0]     fill_bits;
    logic [FILL_W-1:0]     fill_next;

    always_comb begin
        state_next = state;
        fm_rd_en   = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (word_count == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // Reserve room for the word in flight so every return fits.
                fm_rd_en = (issued != count_q) &&
                           ((32'(fill_bits) + (inflight ? 2 * MW : MW)) <= CREDIT);
                // Last read was issued earlier; it returns by this edge at the latest.
                if (issued == count_q) state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (fill_next == '0) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge calc_clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            count_q    <= '0;
            issued     <= '0;
            fm_rd_addr <= '0;
            inflight   <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= fm_rd_en;
            if (accept) begin
                count_q    <= word_count;
                issued     <= '0;
                fm_rd_addr <= base_addr;
            end else if (fm_rd_en) begin
                issued     <= issued + ONE_CNT;
                fm_rd_addr <= fm_rd_addr + ONE_ADDR;
            end
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    fm_bit_packer #(
        .MW        (MW),
        .DDR_WIDTH (DDR_WIDTH),
        .FILL_W    (FILL_W)
    ) u_packer (
        .clk        (calc_clk),
        .rst        (rst),
        .in_valid   (inflight),
        .in_data    (fm_rd_data),
        .flush_next (state_next == ST_FLUSH),
        .out_ready  (ddr_rd_ready),
        .out_data   (ddr_rd_data),
        .out_valid  (ddr_rd_valid),
        .fill_bits  (fill_bits),
        .fill_next  (fill_next)
    );

`ifdef FM_RD_STALL_CNT_EN
    always_ff @(posedge calc_clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (accept) begin
            stall_cnt <= '0;
        end else if (ddr_rd_valid && !ddr_rd_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fm_ddr_readback_ctrl.sv
// Scoreboard bench for fm_ddr_readback_ctrl: a word-stream model queues expected
// addresses and beats at job start; a monitor pops and compares as the DUT presents them.
module tb_fm_ddr_readback_ctrl;

    import fm_pkg::*;

    localparam int MWB  = 144;
    localparam int DDRB = 256;
    localparam int DEP  = 8192;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [12:0]   base_addr;
    logic [13:0]   word_count;
    logic [12:0]   fm_rd_addr;
    logic          fm_rd_en;
    logic [143:0]  fm_rd_data = '0;
    logic [255:0]  ddr_rd_data;
    logic          ddr_rd_valid;
    logic          ddr_rd_ready;
    logic          busy;
    logic          done;
    logic [15:0]   stall_cnt;

    fm_ddr_readback_ctrl #(
        .CONV_OUT_NUM (18),
        .DATA_WIDTH   (8),
        .FM_MEM_DEPTH (13),
        .DDR_WIDTH    (256)
    ) dut (
        .calc_clk     (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .word_count   (word_count),
        .fm_rd_addr   (fm_rd_addr),
        .fm_rd_en     (fm_rd_en),
        .fm_rd_data   (fm_rd_data),
        .ddr_rd_data  (ddr_rd_data),
        .ddr_rd_valid (ddr_rd_valid),
        .ddr_rd_ready (ddr_rd_ready),
        .busy         (busy),
        .done         (done),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [143:0] mem [0:DEP-1];
    always @(posedge clk) if (fm_rd_en) fm_rd_data <= mem[fm_rd_addr];

    int n_checks = 0;
    int n_fail   = 0;

    logic [12:0]  exp_addr [$];
    logic [255:0] exp_beat [$];

    int           ready_mode = 0;
    int           job_start  = 0;
    bit           job_zero   = 0;
    int           first_rd   = -1;
    int           first_valid = -1;
    int           last_xfer  = -100;
    int           stall_job  = 0;
    int           beats_job  = 0;
    int           done_cnt   = 0;
    logic [255:0] first_beat = '0;
    bit           prev_stall = 0;
    logic [255:0] prev_data  = '0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: concatenate words LSB-first into one bit stream and cut it into beats.
    task automatic start_job(input int base, input int cnt, input int mode);
        logic [64*144-1:0] stream;
        int nb;
        stream = '0;
        for (int k = 0; k < cnt; k++) begin
            int a;
            a = (base + k) % DEP;
            exp_addr.push_back(13'(a));
            stream[k*MWB +: MWB] = mem[a];
        end
        nb = (cnt * MWB + DDRB - 1) / DDRB;
        for (int j = 0; j < nb; j++) exp_beat.push_back(stream[j*DDRB +: DDRB]);
        job_start   = cyc;
        job_zero    = (cnt == 0);
        first_rd    = -1;
        first_valid = -1;
        last_xfer   = -100;
        stall_job   = 0;
        beats_job   = 0;
        ready_mode  = mode;
        base_addr   = 13'(base);
        word_count  = 14'(cnt);
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int d0;
        int t;
        d0 = done_cnt;
        t  = 0;
        while (done_cnt == d0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == d0) chk("done_timeout", 256'(0), 256'(1));
    endtask

    // Ready driver: 0 = always, 1 = random, 2 = low for job cycles 5..20.
    initial begin
        ddr_rd_ready = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            case (ready_mode)
                1:       ddr_rd_ready = ($urandom_range(0, 3) != 0);
                2:       ddr_rd_ready = !((cyc - job_start) >= 5 && (cyc - job_start) <= 20);
                default: ddr_rd_ready = 1'b1;
            endcase
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (fm_rd_en) begin
                    if (first_rd < 0) first_rd = cyc;
                    if (exp_addr.size() == 0) chk("rd_en_unexpected", 256'(1), 256'(0));
                    else chk("rd_addr", 256'(fm_rd_addr), 256'(exp_addr.pop_front()));
                end
                if (ddr_rd_valid) begin
                    if (first_valid < 0) first_valid = cyc;
                    if (prev_stall) chk("beat_stable", ddr_rd_data, prev_data);
                    if (ddr_rd_ready) begin
                        if (beats_job == 0) first_beat = ddr_rd_data;
                        beats_job++;
                        last_xfer = cyc;
                        if (exp_beat.size() == 0) chk("beat_unexpected", ddr_rd_data, 256'(0));
                        else chk("beat_data", ddr_rd_data, exp_beat.pop_front());
                    end else begin
                        stall_job++;
                    end
                end else if (prev_stall) begin
                    chk("valid_dropped", 256'(0), 256'(1));
                end
                prev_stall = ddr_rd_valid && !ddr_rd_ready;
                prev_data  = ddr_rd_data;
                if (done) begin
                    done_cnt++;
                    chk("done_beats_left", 256'(exp_beat.size()), 256'(0));
                    chk("done_reads_left", 256'(exp_addr.size()), 256'(0));
                    if (job_zero) chk("done_cycle_zero", 256'(cyc), 256'(job_start + 1));
                    else          chk("done_cycle", 256'(cyc), 256'(last_xfer + 1));
`ifdef FM_RD_STALL_CNT_EN
                    chk("stall_cnt", 256'(stall_cnt), 256'((stall_job > 65535) ? 65535 : stall_job));
`else
                    chk("stall_cnt", 256'(stall_cnt), 256'(0));
`endif
                end
            end
        end
    end

    initial begin
        logic [159:0] r;
        logic [7:0]   bv;
        int           d0;
        int           t;
        for (int i = 0; i < DEP; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom, $urandom};
            mem[i] = r[143:0];
        end
        for (int k = 0; k < 16; k++) begin
            bv = 8'(k);
            mem[k] = {18{bv}};
        end

        rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_rd_en", 256'(fm_rd_en), 256'(0));
        chk("rst_rd_addr", 256'(fm_rd_addr), 256'(0));
        chk("rst_valid", 256'(ddr_rd_valid), 256'(0));
        chk("rst_data", ddr_rd_data, 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_stall", 256'(stall_cnt), 256'(0));

        // Basic 16-word job, started on the edge right after reset release.
        @(negedge clk);
        rst = 1'b0;
        start_job(0, 16, 0);
        wait_done();
        chk("lat_first_rd", 256'(first_rd - job_start), 256'(1));
        chk("lat_first_valid", 256'(first_valid - job_start), 256'(4));
        chk("beats_16w", 256'(beats_job), 256'(FM_RATIO_BEATS));
        chk("beat0_pattern", first_beat, {112'h0101010101010101010101010101, 144'h0});

        // Same job with a backpressure window.
        start_job(0, 16, 2);
        wait_done();

        // Single word: one zero-padded beat.
        start_job(100, 1, 0);
        wait_done();
        chk("one_word_upper", 256'(first_beat[255:144]), 256'(0));
        chk("one_word_beats", 256'(beats_job), 256'(1));

        // Address wrap-around.
        start_job(8190, 4, 0);
        wait_done();

        // Zero-length job; a start while in DONE is ignored.
        d0 = done_cnt;
        start_job(7, 0, 0);
        base_addr = 13'd42; word_count = 14'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("zero_job_done_once", 256'(done_cnt - d0), 256'(1));
        chk("zero_job_idle", 256'(busy), 256'(0));

        // Start pulsed mid-job with different parameters is ignored.
        start_job(300, 12, 1);
        repeat (3) @(negedge clk);
        base_addr = 13'd500; word_count = 14'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Randomized jobs with random backpressure.
        for (int n = 0; n < 6; n++) begin
            start_job(int'($urandom_range(0, DEP - 1)), int'($urandom_range(1, 40)), 1);
            wait_done();
        end

        // Reset during a job after five beats.
        start_job(0, 16, 0);
        t = 0;
        while (beats_job < 5 && t < 500) begin
            @(negedge clk);
            #3;
            t++;
        end
        chk("mid_rst_reached_5_beats", 256'(beats_job >= 5), 256'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_rd_en", 256'(fm_rd_en), 256'(0));
        chk("mid_rst_rd_addr", 256'(fm_rd_addr), 256'(0));
        chk("mid_rst_valid", 256'(ddr_rd_valid), 256'(0));
        chk("mid_rst_data", ddr_rd_data, 256'(0));
        chk("mid_rst_busy", 256'(busy), 256'(0));
        chk("mid_rst_done", 256'(done), 256'(0));
        chk("mid_rst_stall", 256'(stall_cnt), 256'(0));
        exp_addr.delete();
        exp_beat.delete();
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_rst_no_done", 256'(done_cnt), 256'(d0));
        start_job(int'($urandom_range(0, DEP - 1)), 16, 1);
        wait_done();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
